// File: rtl/write_resp_fifo.sv
// Buffers write responses {id, resp} in order and presents them on an AXI B channel.
// Optional zero-latency empty-FIFO bypass is enabled by defining WRESP_BYPASS_EN.
module write_resp_fifo #(
  parameter int ADD_ID_WIDTH = 4,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADD_ID_WIDTH-1:0]    id_in,
  input  logic [1:0]                 resp_in,
  input  logic                       mod2_valid_in,
  output logic                       mod2_ready_out,
  output logic [ADD_ID_WIDTH-1:0]    bid,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_seen
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef struct packed {
    logic [ADD_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_vld, push, push_q, pop;

  // Ready comes from the count register only, so a full FIFO cannot
  // accept in the same cycle it is popped.
  assign mod2_ready_out = (count < DEPTH_C);
  assign fifo_vld       = (count != '0);
  assign head           = mem[rd_ptr];
  assign push           = mod2_valid_in && mod2_ready_out;
  assign pop            = fifo_vld && bready;

`ifdef WRESP_BYPASS_EN
  logic empty;
  assign empty  = (count == '0);
  assign bvalid = fifo_vld || (empty && mod2_valid_in);
  assign bid    = fifo_vld ? head.id   : id_in;
  assign bresp  = fifo_vld ? head.resp : resp_in;
  // A response passed straight through is never stored.
  assign push_q = push && !(empty && bready);
`else
  assign bvalid = fifo_vld;
  assign bid    = head.id;
  assign bresp  = head.resp;
  assign push_q = push;
`endif

  always_ff @(posedge clk) begin
    if (push_q) mem[wr_ptr] <= '{id: id_in, resp: resp_in};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_seen <= 1'b0;
    end else begin
      if (push_q) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_q, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && resp_in[1]) err_seen <= 1'b1;
    end
  end
endmodule

// File: tb/tb_write_resp_fifo.sv
// Directed self-checking bench for write_resp_fifo (DEPTH 4, ID width 4).
module tb_write_resp_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_in;
  logic [1:0] resp_in;
  logic       mod2_valid_in;
  logic       mod2_ready_out;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;
  logic [2:0] count;
  logic       err_seen;
  int checks = 0;
  int errors = 0;

  write_resp_fifo #(.ADD_ID_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .id_in(id_in), .resp_in(resp_in),
    .mod2_valid_in(mod2_valid_in), .mod2_ready_out(mod2_ready_out),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .count(count), .err_seen(err_seen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mod2_valid_in = 1'b0; bready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    id_in = '0; resp_in = '0;
    do_reset();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %0b exp 0", bvalid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (mod2_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", mod2_ready_out); end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err_seen); end
  endtask

  task automatic test_single();
    bready = 1'b1; mod2_valid_in = 1'b1; id_in = 4'd3; resp_in = 2'b00;
    #1;
`ifndef WRESP_BYPASS_EN
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %0b exp 0", bvalid); end
`endif
    tick();
    mod2_valid_in = 1'b0;
    #1;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL single_bvalid got %0b exp 1", bvalid); end
    checks++; if (bid !== 4'd3) begin errors++; $display("FAIL single_bid got %0d exp 3", bid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL single_bresp got %0b exp 00", bresp); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after got %0d exp 0", count); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL single_bvalid_after got %0b exp 0", bvalid); end
  endtask

  task automatic fill4(input logic [3:0] base);
    bready = 1'b0; resp_in = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mod2_valid_in = 1'b1; id_in = base + 4'(i);
      tick();
    end
    mod2_valid_in = 1'b0;
  endtask

  task automatic test_fill();
    fill4(4'd1);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (mod2_ready_out !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b exp 0", mod2_ready_out); end
    mod2_valid_in = 1'b1; id_in = 4'd5;
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_holdoff_count got %0d exp 4", count); end
    checks++; if (bid !== 4'd1 || bvalid !== 1'b1) begin errors++; $display("FAIL fill_stable got bid %0d v %0b exp 1 1", bid, bvalid); end
    mod2_valid_in = 1'b0; bready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (bid !== 4'(i) || bvalid !== 1'b1) begin errors++; $display("FAIL fill_order got bid %0d v %0b exp %0d 1", bid, bvalid, i); end
      tick();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drained got %0d exp 0", count); end
  endtask

  task automatic test_full_pop();
    logic [3:0] exp_ids [4];
    fill4(4'd1);
    mod2_valid_in = 1'b1; id_in = 4'd9; bready = 1'b1;
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d exp 3", count); end
    checks++; if (bid !== 4'd2) begin errors++; $display("FAIL fullpop_head got %0d exp 2", bid); end
    bready = 1'b0;
    tick();
    mod2_valid_in = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_refill got %0d exp 4", count); end
    exp_ids = '{4'd2, 4'd3, 4'd4, 4'd9};
    bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bid !== exp_ids[i]) begin errors++; $display("FAIL fullpop_order got %0d exp %0d", bid, exp_ids[i]); end
      tick();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fullpop_drained got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    bready = 1'b0; mod2_valid_in = 1'b1; id_in = 4'd1; resp_in = 2'b00;
    tick();
    bready = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      id_in = 4'(i);
      tick();
      checks++; if (count !== 3'd1 || bid !== 4'(i)) begin errors++; $display("FAIL b2b got cnt %0d bid %0d exp 1 %0d", count, bid, i); end
    end
    mod2_valid_in = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_drained got %0d exp 0", count); end
  endtask

  task automatic test_err();
    do_reset();
    bready = 1'b0; mod2_valid_in = 1'b1; id_in = 4'd1; resp_in = 2'b00;
    tick();
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL err_okay got %0b exp 0", err_seen); end
    id_in = 4'd2; resp_in = 2'b10;
    tick();
    checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL err_set got %0b exp 1", err_seen); end
    id_in = 4'd3; resp_in = 2'b00;
    tick();
    mod2_valid_in = 1'b0; bready = 1'b1;
    #1;
    checks++; if (bresp !== 2'b00 || bid !== 4'd1) begin errors++; $display("FAIL err_head got bid %0d resp %0b exp 1 00", bid, bresp); end
    tick();
    checks++; if (bresp !== 2'b10 || bid !== 4'd2) begin errors++; $display("FAIL err_slverr got bid %0d resp %0b exp 2 10", bid, bresp); end
    tick(); tick();
    checks++; if (count !== 3'd0 || err_seen !== 1'b1) begin errors++; $display("FAIL err_sticky got cnt %0d err %0b exp 0 1", count, err_seen); end
    do_reset();
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", err_seen); end
  endtask

  task automatic test_reset_mid();
    bready = 1'b0; mod2_valid_in = 1'b1; resp_in = 2'b00;
    id_in = 4'd7; tick();
    id_in = 4'd8; tick();
    mod2_valid_in = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL mid_pre got %0d exp 2", count); end
    do_reset();
    checks++; if (bvalid !== 1'b0 || count !== 3'd0 || mod2_ready_out !== 1'b1) begin errors++; $display("FAIL mid_reset got v %0b cnt %0d rdy %0b exp 0 0 1", bvalid, count, mod2_ready_out); end
    tick();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL mid_stale got %0b exp 0", bvalid); end
    mod2_valid_in = 1'b1; id_in = 4'd6;
    tick();
    mod2_valid_in = 1'b0;
    checks++; if (bid !== 4'd6 || count !== 3'd1) begin errors++; $display("FAIL mid_new got bid %0d cnt %0d exp 6 1", bid, count); end
    bready = 1'b1;
    tick();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL mid_old_reappear got %0b exp 0", bvalid); end
  endtask

`ifdef WRESP_BYPASS_EN
  task automatic test_bypass();
    bready = 1'b1; mod2_valid_in = 1'b1; id_in = 4'd5; resp_in = 2'b01;
    #1;
    checks++; if (bvalid !== 1'b1 || bid !== 4'd5 || bresp !== 2'b01) begin errors++; $display("FAIL byp_out got v %0b bid %0d resp %0b exp 1 5 01", bvalid, bid, bresp); end
    tick();
    mod2_valid_in = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_count got %0d exp 0", count); end
    bready = 1'b0; mod2_valid_in = 1'b1; id_in = 4'd4; resp_in = 2'b00;
    tick();
    mod2_valid_in = 1'b0;
    checks++; if (count !== 3'd1 || bid !== 4'd4) begin errors++; $display("FAIL byp_stall got cnt %0d bid %0d exp 1 4", count, bid); end
    bready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_err();
    test_reset_mid();
`ifdef WRESP_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_resp_fifo.md
WRITE_RESP_FIFO -- requirements
Module: write_resp_fifo

Interface
REQ-001 Parameter ADD_ID_WIDTH, default 4: width of the write-response ID.
REQ-002 Parameter DEPTH, default 4: number of response entries buffered; power of two, >= 2.
REQ-003 Port clk  input  1: single clock; all logic on rising edge.
REQ-004 Port reset  input  1: synchronous, active-low reset.
REQ-005 Port id_in  input  ADD_ID_WIDTH: ID of the response offered by the write-data module.
REQ-006 Port resp_in  input  2: response code offered (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).
REQ-007 Port mod2_valid_in  input  1: upstream response valid.
REQ-008 Port mod2_ready_out  output  1: block can accept a response.
REQ-009 Port bid  output  ADD_ID_WIDTH: AXI B-channel ID.
REQ-010 Port bresp  output  2: AXI B-channel response.
REQ-011 Port bvalid  output  1: AXI B-channel valid.
REQ-012 Port bready  input  1: AXI B-channel ready from master.
REQ-013 Port count  output  $clog2(DEPTH+1): number of entries currently held.
REQ-014 Port err_seen  output  1: sticky flag, set once any SLVERR/DECERR has been accepted.

Function
REQ-015 The block SHALL store {id_in, resp_in} in a circular FIFO of DEPTH entries with write/read pointers wrapping from DEPTH-1 to 0.
REQ-016 A push SHALL occur on a rising edge where mod2_valid_in and mod2_ready_out are both 1.
REQ-017 A pop SHALL occur on a rising edge where bvalid and bready are both 1.
REQ-018 mod2_ready_out SHALL be 1 exactly when count < DEPTH; it SHALL depend only on registered state (no combinational path from bready).
REQ-019 When full, a simultaneous pop SHALL NOT enable a push in the same cycle; the push is accepted on the following cycle.
REQ-020 bvalid SHALL be 1 whenever count > 0; bid/bresp SHALL present the head entry.
REQ-021 Once bvalid is 1, bvalid, bid and bresp SHALL remain stable until the pop handshake completes.
REQ-022 A push in cycle N into a non-empty or empty FIFO SHALL appear on the B channel no earlier than cycle N+1 (bypass disabled).
REQ-023 Simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-024 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow below 0.
REQ-025 err_seen SHALL set on the edge after a push with resp_in[1] == 1 and stay 1 until reset.
REQ-026 Responses SHALL leave in exactly the order accepted; no reordering by ID.

Reset
REQ-027 While reset is 0 at a rising edge, pointers and count SHALL become 0, err_seen 0, bvalid 0, mod2_ready_out 1 on the following cycle.
REQ-028 Reset asserted mid-operation SHALL discard all held entries; no stale entry SHALL appear on the B channel after reset release.
REQ-029 Stored payload registers SHALL NOT require reset; outputs bid/bresp are don't-care while bvalid is 0.

Configuration
REQ-030 Macro WRESP_BYPASS_EN, when defined, SHALL add a zero-latency path: with count == 0, bvalid = mod2_valid_in and bid/bresp = id_in/resp_in combinationally; if bready is also 1 the response is passed and SHALL NOT be written into the FIFO.
REQ-031 With WRESP_BYPASS_EN defined and count == 0 and bready 0, the offered response SHALL be pushed normally and presented from the FIFO next cycle.
REQ-032 Without WRESP_BYPASS_EN, no combinational path SHALL exist from upstream inputs to B-channel outputs; latency per REQ-022.

Verification
REQ-033 Reset, then push ID 3/OKAY with bready 1 -> bvalid 1, bid 3, bresp 00 at cycle N+1 (no bypass), count returns to 0 after pop.
REQ-034 bready 0, push IDs 1,2,3,4 (DEPTH 4) -> count 4, mod2_ready_out 0; fifth response held off; bready 1 -> outputs 1,2,3,4 in order.
REQ-035 Full FIFO, mod2_valid_in 1 and bready 1 together -> pop occurs, no push that cycle; push accepted next cycle, count 4 -> 3 -> 4.
REQ-036 Push resp 10 amid OKAYs -> err_seen 1 from next cycle, remains 1 after FIFO drains; reset -> err_seen 0.
REQ-037 Two entries held, reset asserted one cycle -> bvalid 0, count 0, mod2_ready_out 1 next cycle; no old ID reappears.
REQ-038 With WRESP_BYPASS_EN, empty FIFO, bready 1, push ID 5/EXOKAY -> bvalid 1, bid 5, bresp 01 same cycle, count stays 0.
